// File: rtl/glb_block_framer.sv
// Block framer for the GLB read path: buffers one payload block, then emits {length header, payload}.
// Optional sticky overflow flag `err` is built when GLB_BLOCK_FRAMER_ERR_EN is defined.
module glb_block_framer #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [16:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [16:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
`ifdef GLB_BLOCK_FRAMER_ERR_EN
   ,output logic       err
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      HDR   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_rd_ptr;
   logic [15:0]   r_mem [DEPTH];

   logic w_in_hs;
   logic w_out_hs;
   logic w_tok;
   logic w_full;
   logic w_wr_en;
   logic w_last;

   assign in_ready  = (r_state == FILL);
   assign out_valid = (r_state == HDR) || (r_state == DRAIN);

   assign w_in_hs  = in_valid & in_ready;
   assign w_out_hs = out_valid & out_ready;
   assign w_tok    = in_data[16];
   assign w_full   = (r_count == DEPTH_C);
   assign w_wr_en  = w_in_hs & ~w_tok & ~w_full & ~flush;
   assign w_last   = (r_rd_ptr == (r_count - CW'(1)));

   // Payload storage has no reset; only the count decides what is valid.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_count[AW-1:0]] <= in_data[15:0];
      end
   end

   always_comb begin
      out_data = '0;
      case (r_state)
         HDR:     out_data = {1'b0, 16'(r_count)};
         DRAIN:   out_data = {1'b0, r_mem[r_rd_ptr[AW-1:0]]};
         default: out_data = '0;
      endcase
   end

`ifdef GLB_BLOCK_FRAMER_ERR_EN
   logic r_err;
   assign err = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (flush) begin
         r_err <= 1'b0;
      end else if (w_in_hs && !w_tok && w_full) begin
         r_err <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= FILL;
         r_count  <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_state  <= FILL;
         r_count  <= '0;
         r_rd_ptr <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_in_hs) begin
                  if (w_tok) begin
                     r_state <= HDR;
                  end else if (!w_full) begin
                     r_count <= r_count + CW'(1);
                  end
               end
            end
            HDR: begin
               if (w_out_hs) begin
                  if (r_count == '0) begin
                     r_state <= FILL;
                  end else begin
                     r_rd_ptr <= '0;
                     r_state  <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_out_hs) begin
                  if (w_last) begin
                     r_count  <= '0;
                     r_rd_ptr <= '0;
                     r_state  <= FILL;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + CW'(1);
                  end
               end
            end
            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_glb_block_framer.sv
// Directed testbench for glb_block_framer (DEPTH = 4) using immediate assertions at each check point.
module tb_glb_block_framer;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [16:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef GLB_BLOCK_FRAMER_ERR_EN
   logic        err;
`endif

   int checks;
   int failures;

   glb_block_framer #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef GLB_BLOCK_FRAMER_ERR_EN
      ,.err      (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
      $display("check %s observed=%h expected=%h", tag, got, exp);
   endtask

   // Present one word for a single cycle while in FILL.
   task automatic send(input logic [16:0] w);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready", {16'b0, in_ready}, 17'h1);
      chk("rst_out_valid", {16'b0, out_valid}, 17'h0);
      chk("rst_out_data", out_data, 17'h0);
`ifdef GLB_BLOCK_FRAMER_ERR_EN
      chk("rst_err", {16'b0, err}, 17'h0);
`endif
      rst_n = 1'b1;
      step();

      // Basic 3-word block
      out_ready = 1'b1;
      send(17'h00011);
      send(17'h00022);
      send(17'h00033);
      send(17'h10000);
      chk("b1_hdr_valid", {16'b0, out_valid}, 17'h1);
      chk("b1_hdr", out_data, 17'h00003);
      chk("b1_inrdy0", {16'b0, in_ready}, 17'h0);
      step();
      chk("b1_w0", out_data, 17'h00011);
      chk("b1_inrdy1", {16'b0, in_ready}, 17'h0);
      step();
      chk("b1_w1", out_data, 17'h00022);
      chk("b1_inrdy2", {16'b0, in_ready}, 17'h0);
      step();
      chk("b1_w2", out_data, 17'h00033);
      chk("b1_inrdy3", {16'b0, in_ready}, 17'h0);
      step();
      chk("b1_inrdy_back", {16'b0, in_ready}, 17'h1);
      chk("b1_outvalid_off", {16'b0, out_valid}, 17'h0);

      // Empty block: token only
      send(17'h1ABCD);
      chk("e_hdr_valid", {16'b0, out_valid}, 17'h1);
      chk("e_hdr", out_data, 17'h00000);
      step();
      chk("e_inrdy_back", {16'b0, in_ready}, 17'h1);
      chk("e_outvalid_off", {16'b0, out_valid}, 17'h0);
      send(17'h00055);
      send(17'h10000);
      chk("e_next_hdr", out_data, 17'h00001);
      step();
      chk("e_next_w0", out_data, 17'h00055);
      step();
      chk("e_next_done", {16'b0, in_ready}, 17'h1);

      // Overflow: DEPTH = 4, six words
      send(17'h00001);
      send(17'h00002);
      send(17'h00003);
      send(17'h00004);
`ifdef GLB_BLOCK_FRAMER_ERR_EN
      chk("ov_err_w4", {16'b0, err}, 17'h0);
`endif
      send(17'h00005);
`ifdef GLB_BLOCK_FRAMER_ERR_EN
      chk("ov_err_w5", {16'b0, err}, 17'h1);
`endif
      send(17'h00006);
      send(17'h10000);
      chk("ov_hdr", out_data, 17'h00004);
      step();
      chk("ov_p0", out_data, 17'h00001);
      step();
      chk("ov_p1", out_data, 17'h00002);
      step();
      chk("ov_p2", out_data, 17'h00003);
      step();
      chk("ov_p3", out_data, 17'h00004);
      step();
      chk("ov_done", {16'b0, out_valid}, 17'h0);
`ifdef GLB_BLOCK_FRAMER_ERR_EN
      chk("ov_err_hold", {16'b0, err}, 17'h1);
`endif
      flush = 1'b1;
      step();
      flush = 1'b0;
`ifdef GLB_BLOCK_FRAMER_ERR_EN
      chk("ov_err_flushed", {16'b0, err}, 17'h0);
`endif

      // Back-pressure: out_ready pattern 1,0,0,1,1
      send(17'h000A1);
      send(17'h000A2);
      send(17'h10000);
      chk("bp_hdr", out_data, 17'h00002);
      out_ready = 1'b1;
      step();
      chk("bp_w0_a", out_data, 17'h000A1);
      out_ready = 1'b0;
      step();
      chk("bp_w0_hold1", out_data, 17'h000A1);
      chk("bp_valid_hold", {16'b0, out_valid}, 17'h1);
      out_ready = 1'b0;
      step();
      chk("bp_w0_hold2", out_data, 17'h000A1);
      out_ready = 1'b1;
      step();
      chk("bp_w1", out_data, 17'h000A2);
      out_ready = 1'b1;
      step();
      chk("bp_done_inrdy", {16'b0, in_ready}, 17'h1);
      chk("bp_done_valid", {16'b0, out_valid}, 17'h0);

      // Flush mid-drain
      send(17'h000B1);
      send(17'h000B2);
      send(17'h000B3);
      send(17'h10000);
      chk("fl_hdr", out_data, 17'h00003);
      step();
      chk("fl_w0", out_data, 17'h000B1);
      step();
      chk("fl_w1_shown", out_data, 17'h000B2);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 17'h000EE;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid_off", {16'b0, out_valid}, 17'h0);
      chk("fl_inrdy_on", {16'b0, in_ready}, 17'h1);
      send(17'h000C1);
      send(17'h10000);
      chk("fl_new_hdr", out_data, 17'h00001);
      step();
      chk("fl_new_w0", out_data, 17'h000C1);
      step();

      // Flush in FILL discards the word offered that cycle
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 17'h00077;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      send(17'h10000);
      chk("ff_hdr_zero", out_data, 17'h00000);
      step();

      // Asynchronous reset during HDR
      send(17'h000D1);
      out_ready = 1'b0;
      send(17'h10000);
      chk("ar_hdr_valid", {16'b0, out_valid}, 17'h1);
      chk("ar_hdr", out_data, 17'h00001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid_async", {16'b0, out_valid}, 17'h0);
      chk("ar_inrdy_async", {16'b0, in_ready}, 17'h1);
      step();
      #3;
      rst_n = 1'b1;
      step();
      chk("ar_after_valid", {16'b0, out_valid}, 17'h0);
      out_ready = 1'b1;
      send(17'h10000);
      chk("ar_after_hdr", out_data, 17'h00000);
      chk("ar_after_hdr_valid", {16'b0, out_valid}, 17'h1);
      step();
      chk("ar_final_inrdy", {16'b0, in_ready}, 17'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
